// File: rtl/cpu_run_monitor.sv
// Run controller around the core: sequences core reset after start, counts RUN cycles and
// retired instructions, and ends the run on halt request, PC self-loop or cycle budget.
module cpu_run_monitor #(
    parameter int CNT_W       = 32,
    parameter int PC_W        = 32,
    parameter int RST_CYCLES  = 4,
    parameter int STALL_LIMIT = 8,
    parameter int MAX_CYCLES  = 27500
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  pc,
    input  logic             retire,
    input  logic             halt_req,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [2:0] {S_IDLE, S_RESETTING, S_RUN, S_HALTED, S_TIMEOUT} state_t;

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) + 1 : 1;
    localparam logic [RW-1:0]    RST_LAST   = RW'(RST_CYCLES - 1);
    localparam logic [SW-1:0]    STALL_LAST = SW'((STALL_LIMIT > 0) ? STALL_LIMIT - 1 : 0);
    localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_CYCLES);

    state_t            state_q, state_d;
    logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
    logic [SW-1:0]     stall_cnt_q, stall_cnt_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]  instr_count_q, instr_count_d;
    logic [1:0]        status_q, status_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cyc_inc;
    logic              pc_eq, stall_hit, timeout_hit;

    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        pc_d          = pc_q;
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;
        status_d      = status_q;

        // Counters saturate rather than wrap so a runaway run never looks short.
        cyc_inc     = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CNT_W'(1);
        pc_eq       = (pc == pc_q);
        stall_hit   = (STALL_LIMIT > 0) && pc_eq && (stall_cnt_q == STALL_LAST);
        timeout_hit = (MAX_CYCLES > 0) && (cyc_inc == MAX_C);

        case (state_q)
            S_IDLE, S_HALTED, S_TIMEOUT: begin
                if (start) begin
                    state_d       = S_RESETTING;
                    rst_cnt_d     = '0;
                    cycle_count_d = '0;
                    instr_count_d = '0;
                    status_d      = 2'b00;
                end
            end
            S_RESETTING: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d     = S_RUN;
                    stall_cnt_d = '0;
                    pc_d        = pc;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            S_RUN: begin
                cycle_count_d = cyc_inc;
                if (retire && !(&instr_count_q))
                    instr_count_d = instr_count_q + CNT_W'(1);
                pc_d = pc;
                if (!pc_eq)
                    stall_cnt_d = '0;
                else if (!(&stall_cnt_q))
                    stall_cnt_d = stall_cnt_q + SW'(1);
                if (halt_req) begin
                    state_d  = S_HALTED;
                    status_d = 2'b01;
                end else if (stall_hit) begin
                    state_d  = S_HALTED;
                    status_d = 2'b10;
                end else if (timeout_hit) begin
                    state_d  = S_TIMEOUT;
                    status_d = 2'b11;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cpu_reset_d = (state_d != S_RUN);
        running_d   = (state_d == S_RUN);
        done_d      = (state_d == S_HALTED) || (state_d == S_TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rst_cnt_q     <= '0;
            stall_cnt_q   <= '0;
            pc_q          <= '0;
            cycle_count_q <= '0;
            instr_count_q <= '0;
            status_q      <= 2'b00;
            cpu_reset_q   <= 1'b1;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            pc_q          <= pc_d;
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
            status_q      <= status_d;
            cpu_reset_q   <= cpu_reset_d;
            running_q     <= running_d;
            done_q        <= done_d;
        end
    end

    assign cpu_reset   = cpu_reset_q;
    assign running     = running_q;
    assign done        = done_q;
    assign status      = status_q;
    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;
endmodule
